dac_fifo: RTL

//   Stereo sample buffer that feeds the DAC control circuit. Software (or a DMA

---
 rtl/dac_fifo.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dac_fifo.sv
// Stereo sample FIFO feeding the DAC: pushes packed {left,right} words,
// pops one pair per DAC 'next' pulse; reports level, irq and sticky flags.
// Ports: clk, rst (async, active-low), enable, flush, wr_en/wr_data,
//   full, level, next, sample_l/sample_r, irq, underrun, overflow, clr_flags.
module dac_fifo #(
  parameter int AW       = 5,
  parameter int LOW_MARK = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  output logic          full,
  output logic [AW:0]   level,
  input  logic          next,
  output logic [15:0]   sample_l,
  output logic [15:0]   sample_r,
  output logic          irq,
  output logic          underrun,
  output logic          overflow,
  input  logic          clr_flags
);

  localparam int          DEPTH = 2 ** AW;
  localparam logic [AW:0] W_DEPTH = (AW + 1)'(DEPTH);
  localparam logic [AW:0] W_LOW   = (AW + 1)'(LOW_MARK);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_level;
  logic [15:0]   r_sample_l;
  logic [15:0]   r_sample_r;
  logic          r_underrun;
  logic          r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop_req;
  logic w_push;
  logic w_pop;
  logic w_ovf_ev;
  logic w_udr_ev;

  assign w_full    = (r_level == W_DEPTH);
  assign w_empty   = (r_level == '0);
  assign w_pop_req = next & enable;

  // full/empty are taken from the pre-edge level, so a pop never
  // makes room for a coincident push, and a push never feeds a
  // coincident pop of an empty FIFO.
  assign w_push   = wr_en & ~w_full & ~flush;
  assign w_pop    = w_pop_req & ~w_empty & ~flush;
  assign w_ovf_ev = wr_en & w_full & ~flush;
  assign w_udr_ev = w_pop_req & w_empty & ~flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Muted playback holds silence; an empty pop also yields silence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sample_l <= '0;
      r_sample_r <= '0;
    end else if (flush || !enable) begin
      r_sample_l <= '0;
      r_sample_r <= '0;
    end else if (w_pop_req) begin
      if (w_empty) begin
        r_sample_l <= '0;
        r_sample_r <= '0;
      end else begin
        r_sample_l <= r_mem[r_rd_ptr][31:16];
        r_sample_r <= r_mem[r_rd_ptr][15:0];
      end
    end
  end

  // A new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_underrun <= (r_underrun & ~clr_flags) | w_udr_ev;
      r_overflow <= (r_overflow & ~clr_flags) | w_ovf_ev;
    end
  end

  assign full     = w_full;
  assign level    = r_level;
  assign sample_l = r_sample_l;
  assign sample_r = r_sample_r;
  assign irq      = enable & (r_level <= W_LOW);
  assign underrun = r_underrun;
  assign overflow = r_overflow;

endmodule
